// File: rtl/axis_accu_pkg.sv
// Shared types and constant helpers for the multi-lane AXI-Stream accumulator.
// Limits are built at a fixed wide width and sliced down to ACC_W by the user.
package axis_accu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } accu_state_e;

    localparam int ACC_LIMIT_W = 128;

    // One extra bit per doubling of lanes keeps the beat sum exact.
    function automatic int beat_sum_w(input int elem_w, input int lanes);
        return elem_w + $clog2(lanes);
    endfunction

    function automatic logic [ACC_LIMIT_W-1:0] acc_max_val(input int acc_w);
        logic [ACC_LIMIT_W-1:0] v;
        v = '0;
        for (int i = 0; i < ACC_LIMIT_W; i++) begin
            v[i] = (i < acc_w - 1);
        end
        return v;
    endfunction

    function automatic logic [ACC_LIMIT_W-1:0] acc_min_val(input int acc_w);
        logic [ACC_LIMIT_W-1:0] v;
        v = '0;
        for (int i = 0; i < ACC_LIMIT_W; i++) begin
            v[i] = (i >= acc_w - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/axis_accumulator_mc_lane_adder.sv
// Masked sum of the signed lanes of one beat, registered as pipeline stage 1.
// A lane only contributes when every byte strobe covering it is set.
module axis_lane_adder
    import axis_accu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ELEM_W = 32,
    parameter int LANES  = DATA_W / ELEM_W
) (
    input  logic                                   sys_clk,
    input  logic                                   sys_rst_n,
    input  logic                                   beat_en,
    input  logic [DATA_W-1:0]                      tdata,
    input  logic [DATA_W/8-1:0]                    tkeep,
    output logic [beat_sum_w(ELEM_W, LANES)-1:0]   beat_sum_q,
    output logic                                   beat_vld_q
);

    localparam int SUM_W     = beat_sum_w(ELEM_W, LANES);
    localparam int LANE_KEEP = ELEM_W / 8;

    logic signed [SUM_W-1:0] masked_sum;
    logic        [SUM_W-1:0] beat_sum_d;
    logic                    beat_vld_d;

    always_comb begin
        masked_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (&tkeep[l*LANE_KEEP +: LANE_KEEP]) begin
                masked_sum = masked_sum + SUM_W'($signed(tdata[l*ELEM_W +: ELEM_W]));
            end
        end
    end

    always_comb begin
        beat_sum_d = beat_sum_q;
        beat_vld_d = beat_en;
        if (beat_en) begin
            beat_sum_d = masked_sum;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_sum_q <= '0;
            beat_vld_q <= 1'b0;
        end else begin
            beat_sum_q <= beat_sum_d;
            beat_vld_q <= beat_vld_d;
        end
    end

endmodule

// File: rtl/axis_accumulator_mc.sv
// Multi-lane AXI-Stream accumulator: sums every kept signed element of a packet
// and returns one result beat per packet, with saturate or wrap on overflow.
module axis_accumulator_mc
    import axis_accu_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ELEM_W   = 32,
    parameter int LANES    = DATA_W / ELEM_W,
    parameter int ACC_W    = 48,
    parameter int SAT_MODE = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                accu_en,
    output logic                accu_finished,
    output logic                acc_ovf,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int SUM_W  = beat_sum_w(ELEM_W, LANES);

    localparam logic [ACC_LIMIT_W-1:0] ACC_MAX_FULL = acc_max_val(ACC_W);
    localparam logic [ACC_LIMIT_W-1:0] ACC_MIN_FULL = acc_min_val(ACC_W);
    localparam logic [ACC_W-1:0]       ACC_MAX      = ACC_MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]       ACC_MIN      = ACC_MIN_FULL[ACC_W-1:0];

    accu_state_e             state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic                    s_tready_q, s_tready_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0]       m_tdata_q, m_tdata_d;

    logic                    s_hs;
    logic                    m_hs;
    logic [SUM_W-1:0]        beat_sum_q;
    logic                    beat_vld_q;
    logic signed [ACC_W:0]   wide_sum;
    logic                    wide_ovf;

    assign s_hs = s_axis_tvalid & s_tready_q;
    assign m_hs = m_tvalid_q & m_axis_tready;

    axis_lane_adder #(
        .DATA_W (DATA_W),
        .ELEM_W (ELEM_W),
        .LANES  (LANES)
    ) u_lane_adder (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .beat_en    (s_hs),
        .tdata      (s_axis_tdata),
        .tkeep      (s_axis_tkeep),
        .beat_sum_q (beat_sum_q),
        .beat_vld_q (beat_vld_q)
    );

    // One guard bit above ACC_W; disagreement with the ACC_W sign means overflow,
    // and the guard bit alone tells which limit was crossed.
    always_comb begin
        wide_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'($signed(beat_sum_q));
        wide_ovf = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;

        if (beat_vld_q) begin
            acc_d = wide_sum[ACC_W-1:0];
            if (wide_ovf) begin
                ovf_d = 1'b1;
                if (SAT_MODE != 0) begin
                    acc_d = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                end
            end
        end

        unique case (state_q)
            IDLE: begin
                if (s_hs) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = s_axis_tlast ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (s_hs && s_axis_tlast) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!beat_vld_q) begin
                    state_d    = OUTPUT;
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = DATA_W'(acc_q);
                end
            end
            OUTPUT: begin
                if (m_hs) begin
                    state_d    = IDLE;
                    m_tvalid_d = 1'b0;
                    m_tdata_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        s_tready_d = accu_en && ((state_d == IDLE) || (state_d == ACCUM));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    assign s_axis_tready = s_tready_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = {KEEP_W{m_tvalid_q}};
    assign m_axis_tlast  = m_tvalid_q;
    assign acc_ovf       = ovf_q;
    assign accu_finished = m_hs;

endmodule

// File: tb/tb_axis_accumulator_mc.sv
// Drives three accumulator configurations with the same packets and checks each
// against a packet-level arithmetic model plus hand-computed result values.
module tb_axis_accumulator_mc;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        accu_en;
    logic        s_tvalid;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic        m_tready;

    logic        s_tready   [3];
    logic        m_tvalid   [3];
    logic [63:0] m_tdata    [3];
    logic [7:0]  m_tkeep    [3];
    logic        m_tlast    [3];
    logic        m_ovf      [3];
    logic        m_finished [3];

    int total = 0;
    int bad   = 0;

    int          cfg_acc_w [3] = '{48, 34, 34};
    bit          cfg_sat   [3] = '{1'b1, 1'b1, 1'b0};
    longint      model_acc [3];
    bit          model_ovf [3];
    bit          in_packet = 1'b0;
    int          pkt_cnt   = 0;
    int          fin_cnt   [3] = '{0, 0, 0};
    logic [63:0] exp_q     [3][$];
    bit          exp_ovf_q [3][$];

    always #5 sys_clk = ~sys_clk;

    axis_accumulator_mc dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .accu_en(accu_en),
        .accu_finished(m_finished[0]), .acc_ovf(m_ovf[0]),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[0]),
        .m_axis_tkeep(m_tkeep[0]), .m_axis_tlast(m_tlast[0])
    );

    axis_accumulator_mc #(.ACC_W(34), .SAT_MODE(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .accu_en(accu_en),
        .accu_finished(m_finished[1]), .acc_ovf(m_ovf[1]),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[1]),
        .m_axis_tkeep(m_tkeep[1]), .m_axis_tlast(m_tlast[1])
    );

    axis_accumulator_mc #(.ACC_W(34), .SAT_MODE(0)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .accu_en(accu_en),
        .accu_finished(m_finished[2]), .acc_ovf(m_ovf[2]),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[2]), .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata[2]),
        .m_axis_tkeep(m_tkeep[2]), .m_axis_tlast(m_tlast[2])
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Packet-level model: every accepted beat adds its kept lanes, then the result
    // is clamped or wrapped into the signed range of each configuration.
    task automatic model_beat(input logic [63:0] data, input logic [7:0] keep, input logic last);
        longint beat_sum;
        longint lim;
        beat_sum = 0;
        for (int l = 0; l < 2; l++) begin
            logic [31:0] elem;
            elem = data[l*32 +: 32];
            if (keep[l*4 +: 4] == 4'hF) beat_sum += longint'($signed(elem));
        end
        for (int i = 0; i < 3; i++) begin
            if (!in_packet) begin
                model_acc[i] = 0;
                model_ovf[i] = 1'b0;
            end
            lim = longint'(1) <<< (cfg_acc_w[i] - 1);
            model_acc[i] += beat_sum;
            if (model_acc[i] > lim - 1) begin
                model_ovf[i] = 1'b1;
                model_acc[i] = cfg_sat[i] ? lim - 1 : model_acc[i] - 2 * lim;
            end else if (model_acc[i] < -lim) begin
                model_ovf[i] = 1'b1;
                model_acc[i] = cfg_sat[i] ? -lim : model_acc[i] + 2 * lim;
            end
            if (last) begin
                exp_q[i].push_back(64'(model_acc[i]));
                exp_ovf_q[i].push_back(model_ovf[i]);
            end
        end
        in_packet = !last;
        if (last) pkt_cnt++;
    endtask

    task automatic applyStimulus(input logic [63:0] data, input logic [7:0] keep, input logic last);
        bit done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tkeep  = keep;
        s_tlast  = last;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge sys_clk);
            if (s_tready[0] && s_tready[1] && s_tready[2]) begin
                @(posedge sys_clk);
                model_beat(data, keep, last);
                #1;
                done = 1'b1;
            end
        end
        if (!done) checkOutput("accept timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            if (m_tvalid[0]) seen = 1'b1;
            else begin
                @(posedge sys_clk);
                #1;
            end
        end
        if (!seen) checkOutput("result timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drained();
        bit empty;
        empty = 1'b0;
        for (int n = 0; n < 50 && !empty; n++) begin
            empty = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
            if (!empty) begin
                @(posedge sys_clk);
                #1;
            end
        end
        if (!empty) checkOutput("drain timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s dut%0d tvalid", tag, i), 64'(m_tvalid[i]), 64'd0);
            checkOutput($sformatf("%s dut%0d tdata", tag, i), m_tdata[i], 64'd0);
            checkOutput($sformatf("%s dut%0d tkeep", tag, i), 64'(m_tkeep[i]), 64'd0);
            checkOutput($sformatf("%s dut%0d tlast", tag, i), 64'(m_tlast[i]), 64'd0);
            checkOutput($sformatf("%s dut%0d ovf", tag, i), 64'(m_ovf[i]), 64'd0);
            checkOutput($sformatf("%s dut%0d finished", tag, i), 64'(m_finished[i]), 64'd0);
            checkOutput($sformatf("%s dut%0d tready", tag, i), 64'(s_tready[i]), 64'd0);
        end
    endtask

    // Every cycle: a valid result must match the model head and hold steady until taken.
    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (m_finished[i]) fin_cnt[i]++;
                if (m_tvalid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checkOutput($sformatf("dut%0d unexpected result", i), 64'd1, 64'd0);
                    end else begin
                        checkOutput($sformatf("dut%0d tdata", i), m_tdata[i], exp_q[i][0]);
                        checkOutput($sformatf("dut%0d ovf", i), 64'(m_ovf[i]), 64'(exp_ovf_q[i][0]));
                        checkOutput($sformatf("dut%0d tkeep", i), 64'(m_tkeep[i]), 64'hFF);
                        checkOutput($sformatf("dut%0d tlast", i), 64'(m_tlast[i]), 64'd1);
                        checkOutput($sformatf("dut%0d finished", i), 64'(m_finished[i]), 64'(m_tready));
                        if (m_tready) begin
                            void'(exp_q[i].pop_front());
                            void'(exp_ovf_q[i].pop_front());
                        end
                    end
                end else begin
                    checkOutput($sformatf("dut%0d idle tkeep", i), 64'(m_tkeep[i]), 64'd0);
                    checkOutput($sformatf("dut%0d idle tlast", i), 64'(m_tlast[i]), 64'd0);
                    checkOutput($sformatf("dut%0d idle finished", i), 64'(m_finished[i]), 64'd0);
                end
            end
        end
    end

    initial begin
        int fin_before;
        sys_rst_n = 1'b0;
        accu_en   = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tlast   = 1'b0;
        m_tready  = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check_reset_state("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        accu_en   = 1'b1;
        @(posedge sys_clk);
        #1;

        $display("[TB] 11-beat lane-0 packet");
        fin_before = fin_cnt[0];
        for (int k = 0; k < 11; k++) begin
            applyStimulus({32'hDEADBEEF, 32'(10 - 10 * k)}, 8'h0F, k == 10);
        end
        checkOutput("latency e0", 64'(m_tvalid[0]), 64'd0);
        @(posedge sys_clk);
        #1;
        checkOutput("latency e1", 64'(m_tvalid[0]), 64'd0);
        @(posedge sys_clk);
        #1;
        checkOutput("latency e2", 64'(m_tvalid[0]), 64'd1);
        checkOutput("packet A sum", m_tdata[0], -64'sd440);
        checkOutput("packet A ovf", 64'(m_ovf[0]), 64'd0);
        wait_drained();
        checkOutput("packet A finished pulses", 64'(fin_cnt[0] - fin_before), 64'd1);

        $display("[TB] two-lane packets");
        for (int k = 0; k < 4; k++) applyStimulus({32'd5, 32'hFFFFFFFD}, 8'hFF, k == 3);
        wait_valid();
        checkOutput("packet B sum", m_tdata[0], 64'd8);
        wait_drained();
        for (int k = 0; k < 4; k++) applyStimulus({32'd5, 32'hFFFFFFFD}, (k == 1) ? 8'hF7 : 8'hFF, k == 3);
        wait_valid();
        checkOutput("packet C sum", m_tdata[0], 64'd11);
        wait_drained();

        $display("[TB] overflow packets");
        for (int k = 0; k < 3; k++) applyStimulus(64'h7FFFFFFF_7FFFFFFF, 8'hFF, k == 2);
        wait_valid();
        checkOutput("ovf wide sum", m_tdata[0], 64'd12884901882);
        checkOutput("ovf wide flag", 64'(m_ovf[0]), 64'd0);
        checkOutput("ovf sat sum", m_tdata[1], 64'd8589934591);
        checkOutput("ovf sat flag", 64'(m_ovf[1]), 64'd1);
        checkOutput("ovf wrap sum", m_tdata[2], -64'sd4294967302);
        checkOutput("ovf wrap flag", 64'(m_ovf[2]), 64'd1);
        wait_drained();
        applyStimulus({32'd1, 32'd1}, 8'hFF, 1'b1);
        wait_valid();
        checkOutput("post-ovf sat sum", m_tdata[1], 64'd2);
        checkOutput("post-ovf sat flag", 64'(m_ovf[1]), 64'd0);
        wait_drained();

        $display("[TB] enable gap and output back-pressure");
        for (int k = 1; k <= 3; k++) applyStimulus({32'(k * 100), 32'(k)}, 8'hFF, 1'b0);
        accu_en  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = {32'd400, 32'd4};
        s_tkeep  = 8'hFF;
        s_tlast  = 1'b0;
        @(negedge sys_clk);
        checkOutput("gap tready lag", 64'(s_tready[0]), 64'd1);
        @(posedge sys_clk);
        model_beat({32'd400, 32'd4}, 8'hFF, 1'b0);
        #1;
        s_tdata = {32'd500, 32'd5};
        repeat (4) begin
            @(negedge sys_clk);
            for (int i = 0; i < 3; i++) checkOutput($sformatf("gap dut%0d tready", i), 64'(s_tready[i]), 64'd0);
            @(posedge sys_clk);
            #1;
        end
        accu_en = 1'b1;
        applyStimulus({32'd500, 32'd5}, 8'hFF, 1'b0);
        m_tready   = 1'b0;
        fin_before = fin_cnt[0];
        applyStimulus({32'd600, 32'd6}, 8'hFF, 1'b1);
        repeat (12) @(posedge sys_clk);
        #1;
        checkOutput("held tvalid", 64'(m_tvalid[0]), 64'd1);
        checkOutput("held sum", m_tdata[0], 64'd2121);
        checkOutput("held no finish", 64'(fin_cnt[0] - fin_before), 64'd0);
        m_tready = 1'b1;
        wait_drained();
        checkOutput("held finished pulses", 64'(fin_cnt[0] - fin_before), 64'd1);

        $display("[TB] reset mid-packet");
        for (int k = 0; k < 5; k++) applyStimulus({32'hDEADBEEF, 32'(10 - 10 * k)}, 8'h0F, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = {32'hDEADBEEF, 32'hFFFFFFCE};
        s_tkeep  = 8'h0F;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_state("mid reset");
        s_tvalid  = 1'b0;
        in_packet = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            exp_ovf_q[i].delete();
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        for (int k = 1; k <= 3; k++) applyStimulus({32'hDEADBEEF, 32'(k)}, 8'h0F, k == 3);
        wait_valid();
        for (int i = 0; i < 3; i++) checkOutput($sformatf("fresh dut%0d sum", i), m_tdata[i], 64'd6);
        wait_drained();

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("dut%0d total results", i), 64'(fin_cnt[i]), 64'(pkt_cnt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
